// File: rtl/dsp_sys_arr_pkg.sv
// dsp_sys_arr_pkg: shared types for the dsp systolic array.
// Operand format, PE error codes, operand-streamer FSM states and defaults.
package dsp_sys_arr_pkg;

    typedef logic [31:0] single_float;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        OVERFLOW  = 2'd1,
        UNDERFLOW = 2'd2,
        INVALID   = 2'd3
    } error;

    typedef enum logic [2:0] {
        IDLE,
        SKEW,
        STREAM,
        WAIT_DONE,
        RESULT
    } streamer_state_t;

    localparam int STREAMER_DEPTH = 16;

endpackage

// File: rtl/sf_fifo.sv
// sf_fifo: circular single_float FIFO with occupancy count and flags.
// Ports: push/din write side, pop/head read side (head is the current entry),
// count/full/empty status. A push is taken when full only if a pop coincides.
module sf_fifo
    import dsp_sys_arr_pkg::*;
#(
    parameter int DEPTH = STREAMER_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          push,
    input  logic [31:0]   din,
    input  logic          pop,
    output logic [31:0]   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = CW - 1;

    single_float   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pe_operand_streamer.sv
// pe_operand_streamer: buffers operands and streams a skewed vector into one PE
// edge input, then captures the PE result. Ports: load_* buffer fill,
// start/vec_len/skew control, pe_in_* stream, pe_* PE status, res_* result.
module pe_operand_streamer
    import dsp_sys_arr_pkg::*;
#(
    parameter int DEPTH = STREAMER_DEPTH,
    parameter int LENW  = 8
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            load_valid,
    input  logic [31:0]     load_dat,
    output logic            load_ready,
    input  logic            start,
    input  logic [LENW-1:0] vec_len,
    input  logic [LENW-1:0] skew,
    output logic            busy,
    output logic            pe_in_valid,
    output logic [31:0]     pe_in_dat,
    input  logic            pe_in_ready,
    input  logic            pe_comp_done,
    input  logic [31:0]     pe_accum_sum,
    input  error            pe_user,
    input  logic            pe_error_bit,
    output logic            res_valid,
    output logic [31:0]     res_sum,
    output error            res_user,
    output logic            res_err,
    input  logic            res_ack,
    output logic            underrun
);

    localparam int CW = $clog2(DEPTH) + 1;

    streamer_state_t state_q, state_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic [LENW-1:0] skew_cnt_q, skew_cnt_d;
    logic            res_valid_q, res_valid_d;
    logic [31:0]     res_sum_q, res_sum_d;
    error            res_user_q, res_user_d;
    logic            res_err_q, res_err_d;
    logic            underrun_q, underrun_d;
    logic            init_q, init_d;

    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic [31:0]     head;
    logic            push;
    logic            pop;

    // Holds load_ready low for the first cycle after reset release.
    assign init_d      = 1'b1;
    assign load_ready  = init_q & ~full;
    assign push        = load_valid & load_ready;
    assign pe_in_valid = (state_q == STREAM) & (count != '0);
    assign pop         = pe_in_valid & pe_in_ready;
    assign pe_in_dat   = pe_in_valid ? head : '0;
    assign busy        = (state_q != IDLE);
    assign res_valid   = res_valid_q;
    assign res_sum     = res_sum_q;
    assign res_user    = res_user_q;
    assign res_err     = res_err_q;
    assign underrun    = underrun_q;

    sf_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push),
        .din   (load_dat),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        skew_cnt_d  = skew_cnt_q;
        res_sum_d   = res_sum_q;
        res_user_d  = res_user_q;
        res_err_d   = res_err_q;
        underrun_d  = underrun_q;
        // A capture in RESULT overrides a coincident ack.
        res_valid_d = res_valid_q & ~res_ack;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d      = vec_len;
                    skew_cnt_d = skew;
                    if (vec_len == '0) begin
                        res_sum_d  = '0;
                        res_user_d = NONE;
                        res_err_d  = 1'b0;
                        state_d    = RESULT;
                    end else if (skew != '0) begin
                        state_d = SKEW;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            SKEW: begin
                skew_cnt_d = skew_cnt_q - LENW'(1);
                if (skew_cnt_q <= LENW'(1)) state_d = STREAM;
            end
            STREAM: begin
                if (empty) underrun_d = 1'b1;
                if (pop) begin
                    rem_d = rem_q - LENW'(1);
                    if (rem_q == LENW'(1)) state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (pe_comp_done) begin
                    res_sum_d  = pe_accum_sum;
                    res_user_d = pe_user;
                    res_err_d  = pe_error_bit;
                    state_d    = RESULT;
                end
            end
            RESULT: begin
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            skew_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_user_q  <= NONE;
            res_err_q   <= 1'b0;
            underrun_q  <= 1'b0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            skew_cnt_q  <= skew_cnt_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_user_q  <= res_user_d;
            res_err_q   <= res_err_d;
            underrun_q  <= underrun_d;
            init_q      <= init_d;
        end
    end

endmodule

// File: tb/tb_pe_operand_streamer.sv
// tb_pe_operand_streamer: self-checking bench for pe_operand_streamer.
// Table-driven streams plus directed corner-case sequences.
module tb_pe_operand_streamer;
    import dsp_sys_arr_pkg::*;

    localparam int DEPTH = 16;
    localparam int LENW  = 8;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            load_valid;
    logic [31:0]     load_dat;
    logic            load_ready;
    logic            start;
    logic [LENW-1:0] vec_len;
    logic [LENW-1:0] skew;
    logic            busy;
    logic            pe_in_valid;
    logic [31:0]     pe_in_dat;
    logic            pe_in_ready;
    logic            pe_comp_done;
    logic [31:0]     pe_accum_sum;
    error            pe_user;
    logic            pe_error_bit;
    logic            res_valid;
    logic [31:0]     res_sum;
    error            res_user;
    logic            res_err;
    logic            res_ack;
    logic            underrun;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          hs_cnt = 0;
    logic [31:0] model_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;

    typedef struct {
        int          n_load;
        logic [7:0]  vlen;
        logic [7:0]  skw;
        logic [7:0]  pat;
        logic [31:0] sum;
        error        user;
        logic        err;
        int          lat;
    } vec_t;

    vec_t        tbl[5];
    logic [31:0] fp[4];

    always #5 CLK = ~CLK;

    pe_operand_streamer #(
        .DEPTH (DEPTH),
        .LENW  (LENW)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .load_valid   (load_valid),
        .load_dat     (load_dat),
        .load_ready   (load_ready),
        .start        (start),
        .vec_len      (vec_len),
        .skew         (skew),
        .busy         (busy),
        .pe_in_valid  (pe_in_valid),
        .pe_in_dat    (pe_in_dat),
        .pe_in_ready  (pe_in_ready),
        .pe_comp_done (pe_comp_done),
        .pe_accum_sum (pe_accum_sum),
        .pe_user      (pe_user),
        .pe_error_bit (pe_error_bit),
        .res_valid    (res_valid),
        .res_sum      (res_sum),
        .res_user     (res_user),
        .res_err      (res_err),
        .res_ack      (res_ack),
        .underrun     (underrun)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: loads push the model, handshakes pop and compare.
    always @(negedge CLK) begin
        if (!nRST) begin
            model_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(pe_in_valid), 32'd1);
                check("hold_dat", pe_in_dat, prev_dat);
            end
            if (pe_in_valid && pe_in_ready) begin
                hs_cnt++;
                if (model_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL hs_data: got %h, expected no transfer",
                             pe_in_dat);
                end else begin
                    check("hs_data", pe_in_dat, model_q.pop_front());
                end
            end
            if (load_valid && load_ready) model_q.push_back(load_dat);
            prev_stall = pe_in_valid && !pe_in_ready;
            prev_dat   = pe_in_dat;
        end
    end

    task automatic load_word(input logic [31:0] v);
        int   tries;
        logic acc;
        tries = 0;
        acc   = 1'b0;
        load_valid = 1'b1;
        load_dat   = v;
        while (!acc && tries < 50) begin
            acc = load_ready;
            tick();
            tries++;
        end
        load_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_timeout: got load_ready=0, expected 1");
        end
    endtask

    task automatic wait_res(input string name);
        int k;
        k = 0;
        while (!res_valid && k < 5) begin
            tick();
            k++;
        end
        check(name, 32'(res_valid), 32'd1);
    endtask

    task automatic ack_res(input string name);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check(name, 32'(res_valid), 32'd0);
    endtask

    task automatic finish_pe(input logic [31:0] sum, input error user,
                             input logic err, input string tag);
        pe_accum_sum = sum;
        pe_user      = user;
        pe_error_bit = err;
        pe_comp_done = 1'b1;
        tick();
        pe_comp_done = 1'b0;
        pe_accum_sum = 32'hDEAD_BEEF;
        pe_user      = NONE;
        pe_error_bit = 1'b0;
        wait_res({tag, "_res_valid"});
        check({tag, "_res_sum"}, res_sum, sum);
        check({tag, "_res_user"}, 32'(res_user), 32'(user));
        check({tag, "_res_err"}, 32'(res_err), 32'(err));
    endtask

    task automatic wait_hs(input int hs0, input int n, input int budget);
        int k;
        k = 0;
        while ((hs_cnt - hs0) < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic run_stream(input vec_t t, input int r);
        int    hs0, cyc, first;
        string tag;
        tag   = $sformatf("r%0d", r);
        hs0   = hs_cnt;
        first = 0;
        vec_len = t.vlen;
        skew    = t.skw;
        start   = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        if (pe_in_valid) first = 1;
        while ((hs_cnt - hs0) < int'(t.vlen) && cyc < 300) begin
            pe_in_ready = t.pat[cyc % 8];
            tick();
            cyc++;
            if (first == 0 && pe_in_valid) first = cyc;
        end
        pe_in_ready = 1'b0;
        check({tag, "_lat"}, 32'(first), 32'(t.lat));
        check({tag, "_hs"}, 32'(hs_cnt - hs0), 32'(t.vlen));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_valid_off"}, 32'(pe_in_valid), 32'd0);
        finish_pe(t.sum, t.user, t.err, tag);
        ack_res({tag, "_ack"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, acc;
        fp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        tbl[0] = '{4, 8'd4, 8'd0, 8'hFF, 32'h4120_0000, NONE,      1'b0, 1};
        tbl[1] = '{2, 8'd2, 8'd3, 8'hFF, 32'h4040_0000, OVERFLOW,  1'b0, 4};
        tbl[2] = '{4, 8'd4, 8'd0, 8'h99, 32'h1234_5678, INVALID,   1'b1, 1};
        tbl[3] = '{5, 8'd3, 8'd1, 8'h5A, 32'hC120_0000, UNDERFLOW, 1'b1, 2};
        tbl[4] = '{0, 8'd2, 8'd2, 8'hFF, 32'h3F00_0001, INVALID,   1'b1, 3};

        nRST = 1'b0;
        load_valid = 1'b0;
        load_dat = '0;
        start = 1'b0;
        vec_len = '0;
        skew = '0;
        pe_in_ready = 1'b0;
        pe_comp_done = 1'b0;
        pe_accum_sum = '0;
        pe_user = NONE;
        pe_error_bit = 1'b0;
        res_ack = 1'b0;
        tick();
        tick();

        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(pe_in_valid), 32'd0);
        check("rst_dat", pe_in_dat, 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", res_sum, 32'd0);
        check("rst_res_user", 32'(res_user), 32'(NONE));
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        nRST = 1'b1;
        #1;
        check("rel_load_ready_0", 32'(load_ready), 32'd0);
        tick();
        check("rel_load_ready_1", 32'(load_ready), 32'd1);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < tbl[r].n_load; i++) begin
                if (r == 0) load_word(fp[i]);
                else load_word(32'hA000_0000 + 32'(r << 8) + 32'(i));
            end
            run_stream(tbl[r], r);
        end

        // Zero-length vector completes without the PE.
        vec_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_res("z_res_valid");
        check("z_res_sum", res_sum, 32'd0);
        check("z_res_user", 32'(res_user), 32'(NONE));
        check("z_res_err", 32'(res_err), 32'd0);
        ack_res("z_ack");

        // start while busy is ignored (during SKEW and WAIT_DONE).
        load_word(32'h1111_0001);
        load_word(32'h1111_0002);
        hs0 = hs_cnt;
        vec_len = 8'd2;
        skew = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vec_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_skew_ign", 32'(busy), 32'd1);
        pe_in_ready = 1'b1;
        wait_hs(hs0, 2, 40);
        pe_in_ready = 1'b0;
        check("busy_hs", 32'(hs_cnt - hs0), 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("busy_wd_noresult", 32'(res_valid), 32'd0);
        check("busy_wd_busy", 32'(busy), 32'd1);
        finish_pe(32'hC0A0_0000, OVERFLOW, 1'b0, "busy");

        // Coincident capture and ack: capture wins.
        vec_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("coin_res_valid", 32'(res_valid), 32'd1);
        check("coin_res_sum", res_sum, 32'd0);
        ack_res("coin_ack");

        // Fill past DEPTH, then underrun and refill mid-stream.
        check("pre_underrun", 32'(underrun), 32'd0);
        acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_valid = 1'b1;
            load_dat = 32'h5000_0000 + 32'(i);
            if (load_ready) acc++;
            tick();
        end
        load_valid = 1'b0;
        check("full_pushes", 32'(acc), 32'(DEPTH));
        check("full_load_ready", 32'(load_ready), 32'd0);
        hs0 = hs_cnt;
        pe_in_ready = 1'b1;
        vec_len = 8'd20;
        skew = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_hs(hs0, DEPTH, 40);
        tick();
        tick();
        check("ur_hs16", 32'(hs_cnt - hs0), 32'(DEPTH));
        check("ur_flag", 32'(underrun), 32'd1);
        check("ur_valid", 32'(pe_in_valid), 32'd0);
        check("ur_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) load_word(32'h6000_0000 + 32'(i));
        wait_hs(hs0, 20, 40);
        tick();
        pe_in_ready = 1'b0;
        check("ur_hs20", 32'(hs_cnt - hs0), 32'd20);
        check("ur_wd_valid", 32'(pe_in_valid), 32'd0);
        check("ur_sticky", 32'(underrun), 32'd1);
        finish_pe(32'h41A0_0000, NONE, 1'b0, "ur");
        ack_res("ur_ack");

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) load_word(32'h7000_0000 + 32'(i));
        vec_len = 8'd3;
        skew = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_valid", 32'(pe_in_valid), 32'd1);
        nRST = 1'b0;
        #1;
        check("mid_rst_valid", 32'(pe_in_valid), 32'd0);
        check("mid_rst_dat", pe_in_dat, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_load_ready", 32'(load_ready), 32'd0);
        check("mid_rst_underrun", 32'(underrun), 32'd0);
        tick();
        nRST = 1'b1;
        tick();
        check("mid_rel_load_ready", 32'(load_ready), 32'd1);
        pe_in_ready = 1'b1;
        vec_len = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_empty_valid", 32'(pe_in_valid), 32'd0);
        check("mid_empty_underrun", 32'(underrun), 32'd1);
        check("mid_no_result", 32'(res_valid), 32'd0);
        pe_in_ready = 1'b0;
        nRST = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_operand_streamer.md
Name: pe_operand_streamer

Overview:
- Transmit-side partner of the PE input port. It drives one PE edge input (row or column) of the dsp systolic array and observes that PE's completion outputs.
- Buffers single_float operands loaded by the host or controller. On start it waits a programmable skew, then streams a fixed-length vector into the PE using the valid/ready handshake.
- After the stream it waits for comp_done and captures accum_sum and the user error code for readback.
- One instance per array edge lane; lane index i uses SKEW = i.

Parameters:
- DEPTH, 16, operand buffer entries (power of two, ≥2).
- LENW, 8, width of vector-length and skew fields.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- load_valid  in  1  operand write request.
- load_dat  in  32  single_float operand to buffer.
- load_ready  out  1  buffer not full.
- start  in  1  one-cycle pulse; begin a stream.
- vec_len  in  LENW  number of operands to stream; sampled on start.
- skew  in  LENW  idle cycles between start and the first valid; sampled on start.
- busy  out  1  state ≠ IDLE.
- pe_in_valid  out  1  to PE row_in_valid or col_in_valid.
- pe_in_dat  out  32  to PE row_in_dat or col_in_dat.
- pe_in_ready  in  1  from PE row_in_ready or col_in_ready.
- pe_comp_done  in  1  from PE comp_done.
- pe_accum_sum  in  32  from PE accum_sum.
- pe_user  in  error  from PE user.
- pe_error_bit  in  1  from PE error_bit.
- res_valid  out  1  result registers hold a fresh result; held until res_ack.
- res_sum  out  32  captured accum_sum.
- res_user  out  error  captured user code.
- res_err  out  1  captured error_bit.
- res_ack  in  1  clears res_valid.
- underrun  out  1  sticky: the stream stalled because the buffer was empty.

Behaviour:
- Reset (nRST low, async) sets:
  - state=IDLE, buffer pointers=0, count=0.
  - pe_in_valid=0, pe_in_dat=0.
  - res_valid=0, res_sum=0, res_user=NONE, res_err=0.
  - underrun=0, busy=0. load_ready goes to 1 one cycle after reset release.
- Reset asserted mid-stream aborts immediately. Buffered data is discarded and no result is produced.
- Buffer: circular FIFO of DEPTH×32 with count register.
  - Push when load_valid & load_ready.
  - Pop when pe_in_valid & pe_in_ready.
  - load_ready = (count ≠ DEPTH).
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged, and are allowed even when the buffer is full.
- Output: pe_in_dat is driven combinationally from the buffer head, so there is zero extra latency.
  - pe_in_valid = (state==STREAM) & (count≠0).
  - Once pe_in_valid is asserted, pe_in_valid and pe_in_dat stay stable until the handshake completes (AXI-style). They never drop while pe_in_ready is low.
- Elements in the buffer beyond vec_len remain for the next stream.
- State machine:
  - IDLE: on start, latch vec_len into remaining and skew into skew_cnt.
    - vec_len=0 → RESULT with res_sum=0, res_user=NONE, res_err=0; PE comp_done is not awaited.
    - Otherwise → SKEW if skew≠0, else STREAM.
  - SKEW: decrement skew_cnt each cycle. Leave for STREAM when skew_cnt==1, so the first valid appears exactly skew+1 cycles after start.
  - STREAM: decrement remaining on each handshake.
    - If count==0 while remaining≠0, set underrun (sticky until reset) and hold pe_in_valid low.
    - On the handshake where remaining==1, go to WAIT_DONE.
  - WAIT_DONE: on pe_comp_done, capture pe_accum_sum, pe_user and pe_error_bit, then go to RESULT. A comp_done seen in any other state is ignored.
  - RESULT: set res_valid=1 and go to IDLE in the same cycle.
- res_valid:
  - Clears on res_ack.
  - If a new capture and res_ack coincide, the new capture wins and res_valid stays 1.
- start is ignored unless state==IDLE.
- Loading is allowed in every state, so the buffer can be refilled during a stream.

Decomposition:
- dsp_sys_arr_pkg gains:
  - streamer_state_t enum (IDLE, SKEW, STREAM, WAIT_DONE, RESULT).
  - STREAMER_DEPTH default constant.
- The module reuses the package types single_float and error.
- One sub-module is natural: sf_fifo, a parameterised single_float FIFO with count and full/empty flags.
- An optional wrapper binds the pe_* ports to a PE_if instance through its tb modport.

Test Plan:
- Basic stream: load 4 values (1.0, 2.0, 3.0, 4.0 = 0x3F800000, 0x40000000, 0x40400000, 0x40800000), start with vec_len=4, skew=0, pe_in_ready held 1 → valid on cycles 1–4 with data in order; comp_done with accum_sum=0x41200000 → res_valid=1, res_sum=0x41200000.
- Skew: skew=3, vec_len=2 → first pe_in_valid exactly 4 cycles after start.
- Backpressure: pe_in_ready toggles 1,0,0,1,… → pe_in_dat never changes while valid and not ready; all 4 values delivered once each.
- Full/underrun:
  - Load DEPTH+2 values → load_ready drops after 16 pushes.
  - Start vec_len=20 → underrun=1 after 16 pops; stream completes once 4 more values are loaded.
- Edge cases:
  - vec_len=0 → res_valid next cycle with res_sum=0.
  - start while busy → ignored.
  - res_ack in the same cycle as a new capture → res_valid stays 1.
- Reset mid-stream: deassert nRST during STREAM → all outputs return to reset values immediately, count=0, no result produced.
